// File: rtl/mc_pkg.sv
// Shared constants, encodings and state enum for the multicycle control unit.
package mc_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } src_b_e;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_ALU   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    WB_MEM   = 4'd6,
    MEM_WR   = 4'd7,
    BRANCH   = 4'd8,
    TRAP     = 4'd9
  } state_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/data memory request-ready handshake between control unit and memories.
interface multicycle_control_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
    modport slave  (input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/mc_alu_decode.sv
// R-type ALU operation decode from funct3/funct7[5]; flags unsupported funct3.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output alu_op_e    alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct3)
            3'b000:  alu_op = funct7_b5 ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32-subset control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, with memory ready handshakes and a data-memory timeout trap.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_b5,
    input  logic                 zero,
    multicycle_control_if.master mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 illegal,
    output logic [3:0]           state_o,
    output logic [RET_W-1:0]     retired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    tmo_q, tmo_d;
    logic             illegal_q;
    logic [RET_W-1:0] retired_q;
    logic             ret_inc;
    logic             tmo_hit;
    logic             imem_req_c, dmem_req_c, dmem_we_c;
    alu_op_e          dec_op;
    logic             dec_legal;

    mc_alu_decode u_alu_decode (
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .alu_op    (dec_op),
        .legal     (dec_legal)
    );

    // Limit is judged on the count including the current wait cycle.
    assign tmo_hit = (int'(tmo_q) + 1) >= MEM_TIMEOUT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (state_d == TRAP) illegal_q <= 1'b1;
            if (ret_inc) retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        ret_inc    = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    imem_req_c = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    if (mem.imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b = SRCB_IMM;
                    case (opcode)
                        OP_LW, OP_SW: state_d = MEM_ADDR;
                        OP_RTYPE:     state_d = dec_legal ? EXEC_R : TRAP;
                        OP_BEQ:       state_d = BRANCH;
                        default:      state_d = TRAP;
                    endcase
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = dec_op;
                    state_d   = WB_ALU;
                end
                WB_ALU: begin
                    reg_write = 1'b1;
                    ret_inc   = 1'b1;
                    state_d   = FETCH;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    tmo_d     = '0;
                    state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    dmem_req_c = 1'b1;
                    tmo_d      = tmo_q + 1'b1;
                    if (mem.dmem_ready) state_d = WB_MEM;
                    else if (tmo_hit)   state_d = TRAP;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    ret_inc    = 1'b1;
                    state_d    = FETCH;
                end
                MEM_WR: begin
                    dmem_req_c = 1'b1;
                    dmem_we_c  = 1'b1;
                    tmo_d      = tmo_q + 1'b1;
                    if (mem.dmem_ready) begin
                        ret_inc = 1'b1;
                        state_d = FETCH;
                    end else if (tmo_hit) begin
                        state_d = TRAP;
                    end
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_write  = zero;
                    pc_src    = 1'b1;
                    ret_inc   = 1'b1;
                    state_d   = FETCH;
                end
                TRAP:    state_d = TRAP;
                default: state_d = TRAP;
            endcase
        end
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
    assign illegal      = illegal_q;
    assign state_o      = state_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: builds an expected per-cycle trace from instruction-level rules, then replays it.
module tb_multicycle_control;

    localparam int TMO = 4;
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC = 4'd2, S_WBALU = 4'd3,
                           S_MADDR = 4'd4, S_MRD = 4'd5, S_WBMEM = 4'd6, S_MWR = 4'd7,
                           S_BR = 4'd8, S_TRAP = 4'd9;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;
    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BAD = 4, K_SWTMO = 5, K_SWRST = 6;

    typedef struct {
        logic        rst, ir, dr, z;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        b5;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [31:0] ret;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5, zero;
    logic        ir_write, pc_write, pc_src, alu_src_a, reg_write, mem_to_reg, illegal;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op, state_o;
    logic [31:0] retired;
    logic [15:0] obs_ctl;

    multicycle_control_if mif ();

    multicycle_control #(.MEM_TIMEOUT(TMO), .RET_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
        .zero(zero), .mem(mif), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .state_o(state_o), .retired(retired)
    );

    always #5 clk = ~clk;

    assign obs_ctl = {mif.imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
                      mif.dmem_req, mif.dmem_we, reg_write, mem_to_reg, illegal};

    rec_t        q[$];
    logic [6:0]  c_opc;
    logic [2:0]  c_f3;
    logic        c_b5;
    logic        exp_ill = 1'b0;
    logic [31:0] exp_ret = '0;
    int          errors = 0;
    int          checks = 0;

    task automatic push(input logic r, ir, dr, z, input logic [3:0] st,
                        input logic imr, irw, pcw, pcs, sa, input logic [1:0] sb,
                        input logic [3:0] op, input logic dq, dw, rw, m2r);
        rec_t e;
        e.rst = r; e.ir = ir; e.dr = dr; e.z = z;
        e.opc = c_opc; e.f3 = c_f3; e.b5 = c_b5; e.st = st;
        e.ctl = {imr, irw, pcw, pcs, sa, sb, op, dq, dw, rw, m2r, exp_ill};
        e.ret = exp_ret;
        q.push_back(e);
    endtask

    // Reset cycle: every strobe low, ADD, selects 0; registers still show the pre-reset value.
    task automatic push_rst(input logic [3:0] st);
        push(1, 1, 1, 0, st, 0, 0, 0, 0, 0, 2'b00, OP_ADD, 0, 0, 0, 0);
        exp_ill = 1'b0;
        exp_ret = '0;
    endtask

    task automatic push_trap(input int n);
        exp_ill = 1'b1;
        for (int i = 0; i < n; i++)
            push(0, 1, 1, 0, S_TRAP, 0, 0, 0, 0, 0, 2'b00, OP_ADD, 0, 0, 0, 0);
    endtask

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic b5);
        if (f3 == 3'b111) return OP_AND;
        if (f3 == 3'b110) return OP_OR;
        return b5 ? OP_SUB : OP_ADD;
    endfunction

    // One instruction: iw fetch wait states, dw data wait states, z the zero flag.
    task automatic instr(input int kind, input logic [6:0] opc, input logic [2:0] f3,
                         input logic b5, input int iw, input int dw, input logic z);
        bit rlegal;
        c_opc = opc; c_f3 = f3; c_b5 = b5;
        rlegal = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110);
        for (int i = 0; i < iw; i++)
            push(0, 0, 0, z, S_FETCH, 1, 0, 0, 0, 0, 2'b01, OP_ADD, 0, 0, 0, 0);
        push(0, 1, 0, z, S_FETCH, 1, 1, 1, 0, 0, 2'b01, OP_ADD, 0, 0, 0, 0);
        push(0, 0, 0, z, S_DECODE, 0, 0, 0, 0, 0, 2'b10, OP_ADD, 0, 0, 0, 0);
        if (kind == K_BAD || (kind == K_R && !rlegal)) begin
            push_trap(3);
            push_rst(S_TRAP);
        end else if (kind == K_R) begin
            push(0, 0, 0, z, S_EXEC, 0, 0, 0, 0, 1, 2'b00, ref_alu(f3, b5), 0, 0, 0, 0);
            push(0, 0, 0, z, S_WBALU, 0, 0, 0, 0, 0, 2'b00, OP_ADD, 0, 0, 1, 0);
            exp_ret++;
        end else if (kind == K_LW) begin
            push(0, 0, 0, z, S_MADDR, 0, 0, 0, 0, 1, 2'b10, OP_ADD, 0, 0, 0, 0);
            for (int i = 0; i <= dw; i++)
                push(0, 0, (i == dw), z, S_MRD, 0, 0, 0, 0, 0, 2'b00, OP_ADD, 1, 0, 0, 0);
            push(0, 0, 0, z, S_WBMEM, 0, 0, 0, 0, 0, 2'b00, OP_ADD, 0, 0, 1, 1);
            exp_ret++;
        end else if (kind == K_SW) begin
            push(0, 0, 0, z, S_MADDR, 0, 0, 0, 0, 1, 2'b10, OP_ADD, 0, 0, 0, 0);
            for (int i = 0; i <= dw; i++)
                push(0, 0, (i == dw), z, S_MWR, 0, 0, 0, 0, 0, 2'b00, OP_ADD, 1, 1, 0, 0);
            exp_ret++;
        end else if (kind == K_SWTMO) begin
            push(0, 0, 0, z, S_MADDR, 0, 0, 0, 0, 1, 2'b10, OP_ADD, 0, 0, 0, 0);
            for (int i = 0; i < TMO; i++)
                push(0, 0, 0, z, S_MWR, 0, 0, 0, 0, 0, 2'b00, OP_ADD, 1, 1, 0, 0);
            push_trap(2);
            push_rst(S_TRAP);
        end else if (kind == K_SWRST) begin
            push(0, 0, 0, z, S_MADDR, 0, 0, 0, 0, 1, 2'b10, OP_ADD, 0, 0, 0, 0);
            push(0, 0, 0, z, S_MWR, 0, 0, 0, 0, 0, 2'b00, OP_ADD, 1, 1, 0, 0);
            push_rst(S_MWR);
        end else begin
            push(0, 0, 0, z, S_BR, 0, 0, z, 1, 1, 2'b00, OP_SUB, 0, 0, 0, 0);
            exp_ret++;
        end
    endtask

    initial begin
        int k;
        logic [6:0] bad;
        logic [2:0] f3;
        logic [2:0] bad_f3 [5];
        bad_f3 = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};

        c_opc = 7'b0110011; c_f3 = '0; c_b5 = 1'b0;
        push_rst(S_FETCH);
        instr(K_R,     7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0);
        instr(K_LW,    7'b0000011, 3'b010, 1'b0, 0, 2, 1'b0);
        instr(K_BEQ,   7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1);
        instr(K_BEQ,   7'b1100011, 3'b000, 1'b0, 1, 0, 1'b0);
        instr(K_SW,    7'b0100011, 3'b010, 1'b0, 0, TMO - 1, 1'b0);
        instr(K_LW,    7'b0000011, 3'b010, 1'b0, 2, TMO - 1, 1'b1);
        instr(K_BAD,   7'b0010011, 3'b000, 1'b0, 0, 0, 1'b0);
        instr(K_R,     7'b0110011, 3'b001, 1'b0, 0, 0, 1'b0);
        instr(K_SWTMO, 7'b0100011, 3'b010, 1'b0, 0, 0, 1'b0);
        instr(K_SW,    7'b0100011, 3'b010, 1'b0, 0, 1, 1'b0);
        instr(K_SWRST, 7'b0100011, 3'b010, 1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2: begin
                    f3 = ($urandom_range(0, 2) == 0) ? 3'b111 : (($urandom_range(0, 1) == 0) ? 3'b110 : 3'b000);
                    instr(K_R, 7'b0110011, f3, 1'($urandom), $urandom_range(0, 3), 0, 1'($urandom));
                end
                3, 4: instr(K_LW, 7'b0000011, 3'($urandom), 1'($urandom), $urandom_range(0, 3),
                            $urandom_range(0, TMO - 1), 1'($urandom));
                5, 6: instr(K_SW, 7'b0100011, 3'($urandom), 1'($urandom), $urandom_range(0, 3),
                            $urandom_range(0, TMO - 1), 1'($urandom));
                7, 8: instr(K_BEQ, 7'b1100011, 3'($urandom), 1'($urandom), $urandom_range(0, 3), 0, 1'($urandom));
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        instr(K_R, 7'b0110011, bad_f3[$urandom_range(0, 4)], 1'($urandom), 0, 0, 1'b0);
                    end else begin
                        do bad = 7'($urandom);
                        while (bad == 7'b0110011 || bad == 7'b0000011 || bad == 7'b0100011 || bad == 7'b1100011);
                        instr(K_BAD, bad, 3'($urandom), 1'($urandom), 0, 0, 1'b0);
                    end
                end
            endcase
        end

        rst = 1'b1; opcode = '0; funct3 = '0; funct7_b5 = 1'b0; zero = 1'b0;
        mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);

        foreach (q[i]) begin
            @(negedge clk);
            rst = q[i].rst; mif.imem_ready = q[i].ir; mif.dmem_ready = q[i].dr; zero = q[i].z;
            opcode = q[i].opc; funct3 = q[i].f3; funct7_b5 = q[i].b5;
            #1;
            checks++;
            assert (state_o === q[i].st) else begin
                errors++;
                $error("FAIL state cyc=%0d observed=%0d expected=%0d", i, state_o, q[i].st);
            end
            checks++;
            assert (obs_ctl === q[i].ctl) else begin
                errors++;
                $error("FAIL ctl cyc=%0d st=%0d observed=%h expected=%h", i, q[i].st, obs_ctl, q[i].ctl);
            end
            checks++;
            assert (retired === q[i].ret) else begin
                errors++;
                $error("FAIL retired cyc=%0d observed=%0d expected=%0d", i, retired, q[i].ret);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a multicycle RV32 subset datapath (lw, sw, beq, R-type add/sub/and/or) over shared ALU, register file and memories.
- Issues one-hot-per-phase strobes (PC/IR write, memory request, regfile write, ALU mux selects, ALUOp).
- Handles variable-latency instruction/data memory via ready handshakes, with a data-memory timeout.
- Sits between the instruction register fields and the datapath mux/enable inputs; replaces single-cycle decode for the multicycle core.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for dmem_ready before trapping (≥1).
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_b5  in  1  IR[30]; selects SUB when funct3=000.
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction memory ack; data valid this cycle.
- dmem_ready  in  1  data memory ack; read data valid or write accepted this cycle.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  1  0 = ALU result, 1 = ALUOut register (branch target).
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  write qualifier for dmem_req.
- reg_write  out  1  regfile write enable.
- mem_to_reg  out  1  1 = writeback from memory data.
- illegal  out  1  sticky trap flag.
- state_o  out  4  current state encoding, for debug.
- retired  out  RET_W  count of completed instructions.

Behaviour:
- Reset: rst sampled high forces state FETCH, illegal=0, retired=0, timeout counter=0.
  - During any cycle with rst high, all strobes are 0, alu_op=0010 and selects are 0.
  - Reset applied mid-operation (including during a pending memory access) aborts it; no write strobe is issued in that cycle.
- Defaults in every state: all strobes 0, alu_op=ADD, selects 0 unless listed below.
- FETCH:
  - imem_req=1, alu_src_a=0, alu_src_b=01, ADD.
  - When imem_ready=1, the same cycle asserts ir_write=1 and pc_write=1 (pc_src=0), then moves to DECODE; otherwise stays in FETCH.
- DECODE:
  - alu_src_a=0, alu_src_b=10, ADD (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 → MEM_ADDR; 0110011 → EXEC_R if the ALU decode is legal, else TRAP; 1100011 → BRANCH; any other opcode → TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00; alu_op from funct3/funct7_b5 (000 with b5=0 → ADD, 000 with b5=1 → SUB, 111 → AND, 110 → OR); → WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0; retire; → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD; clears timeout counter; → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: dmem_req=1, dmem_we=0; increments timeout counter each cycle; on dmem_ready → WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1; retire; → FETCH.
- MEM_WR: dmem_req=1, dmem_we=1; increments timeout counter; on dmem_ready, retire and → FETCH.
- Timeout: in MEM_RD or MEM_WR, if the counter reaches MEM_TIMEOUT with dmem_ready=0 → TRAP. dmem_ready arriving in the same cycle the counter hits the limit wins (access completes).
- BRANCH: alu_src_a=1, alu_src_b=00, SUB; pc_write=zero (Mealy), pc_src=1; retire; → FETCH.
- TRAP: illegal=1; all strobes 0; remains in TRAP until rst.
- Retire: retired increments by 1 on the cycle the state leaves WB_ALU, WB_MEM, MEM_WR or BRANCH; wraps modulo 2^RET_W.
- Cycle counts with zero wait states: R-type 4, beq 3, sw 4, lw 5.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants (LW, SW, BEQ, RTYPE);
  - ALUOp codes;
  - alu_src_b encoding;
  - state enum (FETCH=0, DECODE, EXEC_R, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, TRAP).
- One combinational sub-module, mc_alu_decode: funct3 and funct7_b5 in; alu_op and legal out. It is used by both DECODE and EXEC_R.

Test Plan:
- add (opcode 0110011, funct3 000, b5 0), imem_ready=1 → states FETCH, DECODE, EXEC_R, WB_ALU; reg_write in cycle 4 only; retired 0→1.
- lw with dmem_ready delayed 2 cycles → MEM_RD held 3 cycles; dmem_req=1, dmem_we=0 throughout; WB_MEM with mem_to_reg=1; total 7 cycles.
- beq: zero=1 → pc_write=1, pc_src=1 in BRANCH; repeated with zero=0 → pc_write=0; retired increments in both cases.
- opcode 0010011, or R-type funct3 001 → TRAP; illegal=1, no reg_write/dmem_req afterwards; stays until rst, which clears illegal.
- sw with dmem_ready never asserted, MEM_TIMEOUT=4 → TRAP after 4 MEM_WR cycles; no retire.
- rst asserted in the second MEM_WR cycle → next cycle in FETCH, dmem_req=0 during rst, retired=0.
